// File: rtl/mul3_pkg.sv
// mul3_pkg: shared constants and state encoding for the serial
// three-operand multiplier.
//   MUL3_WIDTH : default operand width (product is 2*MUL3_WIDTH bits)
//   MUL3_ITERS : shift-add steps per multiply phase
//   MUL3_CNT_W : width of the per-phase iteration counter
//   state_t    : FSM state encoding, also driven onto the fsm_state debug port
package mul3_pkg;

    localparam int MUL3_WIDTH = 32;
    localparam int MUL3_ITERS = 32;
    localparam int MUL3_CNT_W = $clog2(MUL3_ITERS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_AB = 2'd1,
        MUL_PC = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mul_step.sv
// mul_step: one radix-2 shift-add multiply step, purely combinational.
// The same instance serves both the a*b phase and the (a*b)*c phase.
// Ports:
//   acc        : running partial product (2*WIDTH)
//   mcand      : multiplicand, shifted left each step (2*WIDTH)
//   mplier     : multiplier, shifted right each step (WIDTH)
//   acc_nxt    : acc + mcand when mplier LSB is set, else acc (mod 2^(2*WIDTH))
//   mcand_nxt  : mcand << 1 (top bit discarded)
//   mplier_nxt : mplier >> 1
module mul_step
    import mul3_pkg::*;
#(
    parameter int WIDTH = MUL3_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [2*WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_nxt  = {mcand[2*WIDTH-2:0], 1'b0};
    assign mplier_nxt = {1'b0, mplier[WIDTH-1:1]};

endmodule

// File: rtl/mul3_serial.sv
// mul3_serial: serial multiplier computing the low 2*WIDTH bits of a*b*c.
// Two back-to-back shift-add phases of MUL3_ITERS steps each give a fixed
// latency of 64 cycles from the capture edge to Done_Flag.
//
// Handshake (responder side): in IDLE a sampled valid_data=1 captures a, b, c
// and starts. Done_Flag rises with producto valid and holds until ack=1 is
// sampled in DONE; that edge clears Done_Flag and returns to IDLE. valid_data
// is ignored outside IDLE and ack outside DONE, so IDLE always lasts at
// least one cycle between transactions. ack may be driven combinationally
// from Done_Flag.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, priority over everything
//   a, b, c    : operands, sampled only at the capture edge
//   valid_data : start request / operands valid
//   ack        : result acknowledge
//   producto   : registered product, held until the next completion
//   Done_Flag  : registered result-valid flag
//   fsm_state  : current FSM state (debug visibility)
module mul3_serial
    import mul3_pkg::*;
#(
    parameter int WIDTH = MUL3_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic               valid_data,
    input  logic               ack,
    output logic [2*WIDTH-1:0] producto,
    output logic               Done_Flag,
    output logic [1:0]         fsm_state
);

    localparam int PW = 2 * WIDTH;
    localparam logic [MUL3_CNT_W-1:0] LAST_CNT = MUL3_CNT_W'(MUL3_ITERS - 1);

    state_t                state_q, state_d;
    logic [MUL3_CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [WIDTH-1:0]      c_q, c_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic                  done_q, done_d;

    logic [PW-1:0]         step_acc;
    logic [PW-1:0]         step_mcand;
    logic [WIDTH-1:0]      step_mplier;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .acc_nxt    (step_acc),
        .mcand_nxt  (step_mcand),
        .mplier_nxt (step_mplier)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            c_q      <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            c_q      <= c_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        c_d      = c_q;
        prod_d   = prod_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                if (valid_data) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    c_d      = c;
                    cnt_d    = '0;
                    state_d  = MUL_AB;
                end
            end
            MUL_AB: begin
                // Counter wraps 31 -> 0 so the next phase starts at zero.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Final step result is a*b; it becomes the new multiplicand.
                    acc_d    = '0;
                    mcand_d  = step_acc;
                    mplier_d = c_q;
                    state_d  = MUL_PC;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                end
            end
            MUL_PC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    prod_d  = step_acc;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                end
            end
            DONE: begin
                if (ack) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign producto  = prod_q;
    assign Done_Flag = done_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mul3_serial.sv
// tb_mul3_serial: directed self-checking bench for mul3_serial.
module tb_mul3_serial;
    import mul3_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] a, b, c;
    logic        valid_data;
    logic        ack;
    logic        ack_auto;
    logic        ack_drv;
    logic [63:0] producto;
    logic        Done_Flag;
    logic [1:0]  fsm_state;

    int checks;
    int failures;

    mul3_serial #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .c          (c),
        .valid_data (valid_data),
        .ack        (ack),
        .producto   (producto),
        .Done_Flag  (Done_Flag),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ack = ack_auto ? Done_Flag : ack_drv;

    // Starts a transaction from a negedge; returns cycles from capture edge
    // to Done_Flag seen, and the product. Leaves the bench at a negedge.
    task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic [31:0] tc, input bit hold_valid,
                           output int lat, output logic [63:0] prod);
        a = ta; b = tb_v; c = tc; valid_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) valid_data = 1'b0;
        lat = 0;
        while (!Done_Flag && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        prod = producto;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_data = 1'b0; ack_auto = 1'b1; ack_drv = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (producto !== 64'd0 || Done_Flag !== 1'b0 || fsm_state !== 2'(IDLE)) begin
            failures++;
            $display("FAIL reset_state: producto=%h done=%b state=%0d, need 0/0/0",
                     producto, Done_Flag, fsm_state);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [63:0] p;
        run_txn(32'd4, 32'd3, 32'd2, 1'b0, lat, p);
        checks++;
        if (lat !== 64) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles, need 64", lat);
        end
        checks++;
        if (p !== 64'd24) begin
            failures++;
            $display("FAIL basic_product: got %0d, need 24", p);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Done_Flag !== 1'b0 || fsm_state !== 2'(IDLE)) begin
            failures++;
            $display("FAIL basic_done_one_cycle: done=%b state=%0d, need 0/IDLE",
                     Done_Flag, fsm_state);
        end
    endtask

    task automatic test_max();
        int lat; logic [63:0] p;
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, p);
        checks++;
        if (p !== 64'h0000_0002_FFFF_FFFF || lat !== 64) begin
            failures++;
            $display("FAIL max_operands: got %h lat %0d, need 00000002ffffffff lat 64", p, lat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat; logic [63:0] p;
        run_txn(32'd0, 32'd7, 32'd9, 1'b0, lat, p);
        checks++;
        if (p !== 64'd0) begin
            failures++;
            $display("FAIL zero_product: got %h, need 0", p);
        end
        checks++;
        if (lat !== 64) begin
            failures++;
            $display("FAIL zero_latency: got %0d, need 64", lat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_ack_hold();
        int lat; logic [63:0] p;
        int bad;
        ack_auto = 1'b0; ack_drv = 1'b0;
        run_txn(32'd6, 32'd7, 32'd3, 1'b0, lat, p);
        checks++;
        if (p !== 64'd126) begin
            failures++;
            $display("FAIL hold_product: got %0d, need 126", p);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (Done_Flag !== 1'b1 || producto !== 64'd126) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable: %0d unstable cycles, need 0", bad);
        end
        ack_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ack_drv = 1'b0;
        checks++;
        if (Done_Flag !== 1'b0 || fsm_state !== 2'(IDLE) || producto !== 64'd126) begin
            failures++;
            $display("FAIL hold_release: done=%b state=%0d prod=%0d, need 0/IDLE/126",
                     Done_Flag, fsm_state, producto);
        end
        ack_auto = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        int lat; logic [63:0] p;
        int lat2;
        a = 32'd4; b = 32'd3; c = 32'd2; valid_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (fsm_state !== 2'(MUL_AB)) begin
            failures++;
            $display("FAIL change_in_mul_ab: state=%0d, need %0d", fsm_state, MUL_AB);
        end
        a = 32'd5; b = 32'd5; c = 32'd5;
        lat = 0;
        while (!Done_Flag && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (producto !== 64'd24) begin
            failures++;
            $display("FAIL change_first: got %0d, need 24", producto);
        end
        // ack edge returns to IDLE, next edge captures 5,5,5: 66 cycles to done.
        lat2 = 0;
        @(posedge clk);
        @(negedge clk);
        lat2++;
        while (!Done_Flag && lat2 < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat2++;
        end
        valid_data = 1'b0;
        checks++;
        if (producto !== 64'd125 || lat2 !== 66) begin
            failures++;
            $display("FAIL change_second: got %0d after %0d cycles, need 125 after 66",
                     producto, lat2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat; logic [63:0] p;
        int early;
        a = 32'd4; b = 32'd3; c = 32'd2; valid_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_data = 1'b0;
        early = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (Done_Flag !== 1'b0) early++;
        end
        checks++;
        if (fsm_state !== 2'(MUL_PC) || early != 0) begin
            failures++;
            $display("FAIL abort_pre: state=%0d early_done=%0d, need MUL_PC/0",
                     fsm_state, early);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (fsm_state !== 2'(IDLE) || producto !== 64'd0 || Done_Flag !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: state=%0d prod=%h done=%b, need IDLE/0/0",
                     fsm_state, producto, Done_Flag);
        end
        run_txn(32'd4, 32'd3, 32'd2, 1'b0, lat, p);
        checks++;
        if (p !== 64'd24 || lat !== 64) begin
            failures++;
            $display("FAIL abort_restart: got %0d lat %0d, need 24 lat 64", p, lat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ack_hold();
        test_operand_change();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
